// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-unit signal bundle: Decode/Execute register fields in,
// forwarding selects, stall/flush controls and tracked M/W state out.
interface hazard_ctrl_if;
    logic [31:0] Instr_D;
    logic [4:0]  Rs1_E;
    logic [4:0]  Rs2_E;
    logic [4:0]  RD_E;
    logic        RF_WE_E;
    logic        Result_E;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic        ForwardA_D;
    logic        ForwardB_D;
    logic        Stall_F;
    logic        Stall_D;
    logic        Flush_E;
    logic [4:0]  RD_M;
    logic [4:0]  RD_W;
    logic        RF_WE_M;
    logic        RF_WE_W;
    logic        Result_M;
    logic [15:0] Stall_cnt;

    modport master (
        output Instr_D, Rs1_E, Rs2_E, RD_E, RF_WE_E, Result_E,
        input  ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D,
        input  Stall_F, Stall_D, Flush_E,
        input  RD_M, RD_W, RF_WE_M, RF_WE_W, Result_M, Stall_cnt
    );

    modport slave (
        input  Instr_D, Rs1_E, Rs2_E, RD_E, RF_WE_E, Result_E,
        output ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D,
        output Stall_F, Stall_D, Flush_E,
        output RD_M, RD_W, RF_WE_M, RF_WE_W, Result_M, Stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: tracks the destination register through M
// and W, selects ALU/Decode bypasses and raises a one-cycle load-use stall.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    logic [4:0]  rd_m_q, rd_m_d;
    logic        rf_we_m_q, rf_we_m_d;
    logic        ld_m_q, ld_m_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic        rf_we_w_q, rf_we_w_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [4:0]  rs1_d_s;
    logic [4:0]  rs2_d_s;
    logic        lw_stall_s;
    logic [1:0]  fwd_a_e_s;
    logic [1:0]  fwd_b_e_s;
    logic        fwd_a_d_s;
    logic        fwd_b_d_s;

    // M result is newer than W, so it takes precedence when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic reg_hit(
        input logic [4:0] rs,
        input logic [4:0] rd,
        input logic       we
    );
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    assign rs1_d_s = hz.Instr_D[19:15];
    assign rs2_d_s = hz.Instr_D[24:20];

    // Forwarding selects and load-use detection, all same-cycle.
    always_comb begin
        fwd_a_e_s  = fwd_sel(hz.Rs1_E, rd_m_q, rf_we_m_q, rd_w_q, rf_we_w_q);
        fwd_b_e_s  = fwd_sel(hz.Rs2_E, rd_m_q, rf_we_m_q, rd_w_q, rf_we_w_q);
        fwd_a_d_s  = reg_hit(rs1_d_s, rd_w_q, rf_we_w_q);
        fwd_b_d_s  = reg_hit(rs2_d_s, rd_w_q, rf_we_w_q);
        lw_stall_s = hz.Result_E & hz.RF_WE_E & (hz.RD_E != 5'd0) &
                     ((hz.RD_E == rs1_d_s) | (hz.RD_E == rs2_d_s));
    end

    // Next state: tracking never freezes, so a stall's bubble flows on to M and W.
    always_comb begin
        rd_m_d      = hz.RD_E;
        rf_we_m_d   = hz.RF_WE_E;
        ld_m_d      = hz.Result_E;
        rd_w_d      = rd_m_q;
        rf_we_w_d   = rf_we_m_q;
        stall_cnt_d = stall_cnt_q;
        if (lw_stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset taking priority over the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_m_q      <= 5'd0;
            rf_we_m_q   <= 1'b0;
            ld_m_q      <= 1'b0;
            rd_w_q      <= 5'd0;
            rf_we_w_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            rd_m_q      <= rd_m_d;
            rf_we_m_q   <= rf_we_m_d;
            ld_m_q      <= ld_m_d;
            rd_w_q      <= rd_w_d;
            rf_we_w_q   <= rf_we_w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.ForwardA_E = fwd_a_e_s;
    assign hz.ForwardB_E = fwd_b_e_s;
    assign hz.ForwardA_D = fwd_a_d_s;
    assign hz.ForwardB_D = fwd_b_d_s;
    assign hz.Stall_F    = lw_stall_s;
    assign hz.Stall_D    = lw_stall_s;
    assign hz.Flush_E    = lw_stall_s;
    assign hz.RD_M       = rd_m_q;
    assign hz.RD_W       = rd_w_q;
    assign hz.RF_WE_M    = rf_we_m_q;
    assign hz.RF_WE_W    = rf_we_w_q;
    assign hz.Result_M   = ld_m_q;
    assign hz.Stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, saturation sequence and
// randomized traffic compared against a pipeline-history reference model.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: history of the last two E-stage records plus counter.
    typedef struct {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } stage_t;
    stage_t hist [2];   // hist[0] = one cycle ago (M), hist[1] = two cycles ago (W)
    int     mdl_cnt;

    // Values sampled at the most recent negedge.
    logic [1:0]  smp_fa_e, smp_fb_e;
    logic        smp_fa_d, smp_fb_d, smp_stall;
    logic [15:0] smp_cnt;

    typedef struct {
        logic       rst;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       we_e, ld_e;
        logic [1:0] fa_e, fb_e;
        logic       fa_d, fb_d, stall;
        logic [15:0] cnt;
    } vec_t;
    vec_t vecs [15];

    function automatic vec_t mk(
        input logic r, input logic [4:0] s1d, input logic [4:0] s2d,
        input logic [4:0] s1e, input logic [4:0] s2e, input logic [4:0] rde,
        input logic we, input logic ld,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic fad, input logic fbd, input logic st, input logic [15:0] c);
        vec_t v;
        v.rst = r; v.rs1_d = s1d; v.rs2_d = s2d; v.rs1_e = s1e; v.rs2_e = s2e;
        v.rd_e = rde; v.we_e = we; v.ld_e = ld; v.fa_e = fa; v.fb_e = fb;
        v.fa_d = fad; v.fb_d = fbd; v.stall = st; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] mdl_fwd(input logic [4:0] rs);
        if (hist[0].we && hist[0].rd != 5'd0 && hist[0].rd == rs) return 2'b10;
        if (hist[1].we && hist[1].rd != 5'd0 && hist[1].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: drive inputs, compare at negedge, advance model at posedge.
    task automatic step(
        input logic r, input logic [4:0] s1d, input logic [4:0] s2d,
        input logic [4:0] s1e, input logic [4:0] s2e, input logic [4:0] rde,
        input logic we, input logic ld, input bit do_check);
        logic st;
        rst           = r;
        hz.Instr_D    = {7'd0, s2d, s1d, 15'd0};
        hz.Rs1_E      = s1e;
        hz.Rs2_E      = s2e;
        hz.RD_E       = rde;
        hz.RF_WE_E    = we;
        hz.Result_E   = ld;
        st = ld && we && (rde != 5'd0) && ((rde == s1d) || (rde == s2d));
        @(negedge clk);
        smp_fa_e  = hz.ForwardA_E;
        smp_fb_e  = hz.ForwardB_E;
        smp_fa_d  = hz.ForwardA_D;
        smp_fb_d  = hz.ForwardB_D;
        smp_stall = hz.Stall_F;
        smp_cnt   = hz.Stall_cnt;
        if (do_check) begin
            chk("mdl_fwdA_E", {30'd0, hz.ForwardA_E}, {30'd0, mdl_fwd(s1e)});
            chk("mdl_fwdB_E", {30'd0, hz.ForwardB_E}, {30'd0, mdl_fwd(s2e)});
            chk("mdl_fwdA_D", {31'd0, hz.ForwardA_D},
                {31'd0, hist[1].we && hist[1].rd != 5'd0 && hist[1].rd == s1d});
            chk("mdl_fwdB_D", {31'd0, hz.ForwardB_D},
                {31'd0, hist[1].we && hist[1].rd != 5'd0 && hist[1].rd == s2d});
            chk("mdl_stall", {29'd0, hz.Stall_F, hz.Stall_D, hz.Flush_E}, {29'd0, st, st, st});
            chk("mdl_track", {20'd0, hz.RD_M, hz.RF_WE_M, hz.Result_M, hz.RD_W, hz.RF_WE_W},
                {20'd0, hist[0].rd, hist[0].we, hist[0].ld, hist[1].rd, hist[1].we});
            chk("mdl_cnt", {16'd0, hz.Stall_cnt}, mdl_cnt);
        end
        @(posedge clk);
        if (r) begin
            hist[0] = '{5'd0, 1'b0, 1'b0};
            hist[1] = '{5'd0, 1'b0, 1'b0};
            mdl_cnt = 0;
        end else begin
            if (st) mdl_cnt = (mdl_cnt + 1 > 65535) ? 65535 : mdl_cnt + 1;
            hist[1] = hist[0];
            hist[0] = '{rde, we, ld};
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mdl_cnt  = 0;
        hist[0]  = '{5'd0, 1'b0, 1'b0};
        hist[1]  = '{5'd0, 1'b0, 1'b0};

        //            rst   s1d    s2d    s1e    s2e    rde    we    ld    faE    fbE    faD   fbD   st    cnt
        vecs[0]  = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[2]  = mk(1'b0, 5'd0,  5'd0,  5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[3]  = mk(1'b0, 5'd5,  5'd5,  5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 16'd0);
        vecs[4]  = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd7,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[5]  = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd7,  5'd7,  1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[6]  = mk(1'b0, 5'd9,  5'd0,  5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[7]  = mk(1'b0, 5'd0,  5'd3,  5'd0,  5'd0,  5'd3,  1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'd0);
        vecs[8]  = mk(1'b0, 5'd0,  5'd3,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[9]  = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[10] = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd9,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[11] = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[12] = mk(1'b0, 5'd9,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[13] = mk(1'b1, 5'd0,  5'd3,  5'd0,  5'd0,  5'd3,  1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'd1);
        vecs[14] = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);

        repeat (2) step(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].rs1_d, vecs[i].rs2_d, vecs[i].rs1_e, vecs[i].rs2_e,
                 vecs[i].rd_e, vecs[i].we_e, vecs[i].ld_e, 1'b1);
            chk($sformatf("vec%0d_fwdA_E", i), {30'd0, smp_fa_e}, {30'd0, vecs[i].fa_e});
            chk($sformatf("vec%0d_fwdB_E", i), {30'd0, smp_fb_e}, {30'd0, vecs[i].fb_e});
            chk($sformatf("vec%0d_fwd_D", i), {30'd0, smp_fa_d, smp_fb_d},
                {30'd0, vecs[i].fa_d, vecs[i].fb_d});
            chk($sformatf("vec%0d_stall", i), {31'd0, smp_stall}, {31'd0, vecs[i].stall});
            chk($sformatf("vec%0d_cnt", i), {16'd0, smp_cnt}, {16'd0, vecs[i].cnt});
        end

        // Saturation: 65534 back-to-back load-use stalls, then 3 more.
        for (int i = 0; i < 65534; i++)
            step(1'b0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("sat_preload", {16'd0, hz.Stall_cnt}, 32'd65534);
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("sat_ffff", {16'd0, hz.Stall_cnt}, 32'h0000FFFF);
        step(1'b1, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("sat_rst_cnt", {16'd0, hz.Stall_cnt}, 32'd0);
        chk("sat_rst_track", {20'd0, hz.RD_M, hz.RF_WE_M, hz.Result_M, hz.RD_W, hz.RF_WE_W}, 32'd0);

        // Randomized traffic over a small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 Instr_D  input  32  instruction in Decode; Rs1_D = Instr_D[19:15], Rs2_D = Instr_D[24:20].
REQ-004 Rs1_E, Rs2_E, RD_E  input  5 each  source/destination register numbers held in the Execute register.
REQ-005 RF_WE_E  input  1  Execute-stage instruction writes the register file.
REQ-006 Result_E  input  1  Execute-stage instruction is a load (result comes from data memory).
REQ-007 ForwardA_E, ForwardB_E  output  2 each  ALU operand select: 00 = register file, 10 = M-stage result, 01 = W-stage result.
REQ-008 ForwardA_D, ForwardB_D  output  1 each  Decode read bypass: select RF_WD over the register-file read data.
REQ-009 Stall_F, Stall_D  output  1 each  hold the Fetch PC and the Decode instruction register.
REQ-010 Flush_E  output  1  load a bubble into the Execute register; all control fields are cleared.
REQ-011 RD_M, RD_W  output  5 each; RF_WE_M, RF_WE_W  output  1 each  tracked destination register and write enable in the M and W stages.
REQ-012 Stall_cnt  output  16  count of load-use stall cycles.

Function
REQ-013 Each clock: the M tracking register takes {RD_E, RF_WE_E, Result_E}, and the W tracking register takes the M values.
REQ-014 Tracking is one cycle per stage: an instruction in E at cycle n appears in M at n+1 and in W at n+2.
REQ-015 ForwardA_E is 10 when RF_WE_M=1, RD_M!=0 and RD_M==Rs1_E.
REQ-016 Otherwise ForwardA_E is 01 when RF_WE_W=1, RD_W!=0 and RD_W==Rs1_E.
REQ-017 Otherwise ForwardA_E is 00.
REQ-018 ForwardB_E follows REQ-015..017 with Rs2_E; when both M and W match, M wins.
REQ-019 ForwardA_D is 1 when RF_WE_W=1, RD_W!=0 and RD_W==Rs1_D; ForwardB_D is the same check with Rs2_D.
REQ-020 Load-use hazard: lw_stall = Result_E & RF_WE_E & (RD_E!=0) & ((RD_E==Rs1_D) | (RD_E==Rs2_D)).
REQ-021 Stall_F = Stall_D = Flush_E = lw_stall, combinational within the same cycle.
REQ-022 A stall lasts exactly one cycle; the next cycle E holds a bubble (RF_WE_E=0), so lw_stall deasserts.
REQ-023 The M tracking register must not be frozen during a stall; the bubble propagates through M and W with RF_WE=0.
REQ-024 Register x0 never matches for forwarding, bypass or stall, even when a write enable is set.
REQ-025 Stall_cnt increments by 1 on each rising edge where lw_stall=1 and rst=0.
REQ-026 Stall_cnt saturates at 16'hFFFF and does not wrap.
REQ-027 All forward, stall and flush outputs are combinational from the tracked state and the inputs; they have no added latency.

Reset
REQ-028 When rst=1 at a rising edge: RD_M, RD_W, RF_WE_M, RF_WE_W, the M load flag and Stall_cnt all become 0.
REQ-029 After reset, with the E inputs at zero, all forward, stall and flush outputs are 0.
REQ-030 Reset asserted while a stall is active clears tracked state and the counter on that edge, and rst has priority over the increment.
REQ-031 Outputs are valid in the first cycle after rst deasserts.

Verification
REQ-032 ALU to ALU: E = add x5 (RF_WE_E=1, RD_E=5); next cycle Rs1_E=5 -> ForwardA_E=10; the cycle after, Rs1_E=5 -> ForwardA_E=01.
REQ-033 Double match: RD_M=RD_W=7, both write enables set, Rs2_E=7 -> ForwardB_E=10.
REQ-034 Load-use: Result_E=1, RF_WE_E=1, RD_E=3, Instr_D[24:20]=3 -> Stall_F=Stall_D=Flush_E=1 for one cycle; Stall_cnt goes 0 -> 1; the next cycle drives the bubble and no stall occurs.
REQ-035 x0: RD_E=0 with a load and Rs1_D=0 -> no stall; RD_M=0 with RF_WE_M=1 and Rs1_E=0 -> ForwardA_E=00.
REQ-036 W to D bypass: RD_W=9, RF_WE_W=1, Instr_D[19:15]=9 -> ForwardA_D=1.
REQ-037 Saturation: preload 65534 stalls, apply 3 more -> Stall_cnt=16'hFFFF; then rst=1 for one cycle -> Stall_cnt=0 and all tracked state is 0.
